// File: rtl/rv_pipe_pkg.sv
// Shared constants and PC-select encoding for the RISC-V pipeline stages.
// The fetch stage, its interface and the bench all pull XLEN and the reset defaults from here.
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEL_SEQ,
        PCSEL_HOLD,
        PCSEL_TARGET
    } pc_sel_e;

    // Fetch addresses are always word aligned; the low bits of a target are dropped.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours (hazard unit, execute, imem, decode).
// The slave side is the fetch stage; the master side is whoever drives hazards and redirects.
interface fetch_stage_if
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic            stallF;
    logic            stallD;
    logic            flushD;
    logic            pc_src_E;
    logic [XLEN-1:0] pc_target_E;
    logic [XLEN-1:0] instr_F;
    logic [XLEN-1:0] pc_F;
    logic [XLEN-1:0] instr_D;
    logic [XLEN-1:0] pc_D;
    logic [XLEN-1:0] pc_plus4_D;
    logic            valid_D;
    logic            misalign_D;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  stallF, stallD, flushD, pc_src_E, pc_target_E, instr_F,
        output pc_F, instr_D, pc_D, pc_plus4_D, valid_D, misalign_D, stall_cnt, flush_cnt
    );

    modport master (
        output stallF, stallD, flushD, pc_src_E, pc_target_E, instr_F,
        input  pc_F, instr_D, pc_D, pc_plus4_D, valid_D, misalign_D, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, for debug visibility.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, PC+4, redirect/hold select and the IF/ID pipeline register.
// Every output is a flop, so nothing combinational reaches decode or imem from the inputs.
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP,
    parameter int              CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);

    pc_sel_e         w_pcSel;
    logic [XLEN-1:0] w_pcNext;
    logic [XLEN-1:0] w_pcPlus4F;
    logic            w_misalignNext;
    logic [XLEN-1:0] r_pcF;
    logic            r_misalignF;
    logic [XLEN-1:0] r_instrD;
    logic [XLEN-1:0] r_pcD;
    logic [XLEN-1:0] r_pcPlus4D;
    logic            r_validD;
    logic            r_misalignD;

    assign w_pcPlus4F = r_pcF + 32'd4;

    // Redirect beats stallF: the instruction causing the stall is being squashed anyway.
    always_comb begin
        w_pcSel        = PCSEL_SEQ;
        w_pcNext       = w_pcPlus4F;
        w_misalignNext = 1'b0;
        if (bus.pc_src_E) begin
            w_pcSel = PCSEL_TARGET;
        end else if (bus.stallF) begin
            w_pcSel = PCSEL_HOLD;
        end
        case (w_pcSel)
            PCSEL_TARGET: begin
                w_pcNext       = alignPc(bus.pc_target_E);
                w_misalignNext = (bus.pc_target_E[1:0] != 2'b00);
            end
            PCSEL_HOLD: begin
                w_pcNext       = r_pcF;
                w_misalignNext = r_misalignF;
            end
            default: begin
                w_pcNext       = w_pcPlus4F;
                w_misalignNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcF       <= RESET_PC;
            r_misalignF <= 1'b0;
        end else begin
            r_pcF       <= w_pcNext;
            r_misalignF <= w_misalignNext;
        end
    end

    // Flush wins over stallD so a squashed slot never lingers in decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instrD    <= NOP_INSTR;
            r_pcD       <= '0;
            r_pcPlus4D  <= '0;
            r_validD    <= 1'b0;
            r_misalignD <= 1'b0;
        end else if (bus.flushD) begin
            r_instrD    <= NOP_INSTR;
            r_pcD       <= '0;
            r_pcPlus4D  <= '0;
            r_validD    <= 1'b0;
            r_misalignD <= 1'b0;
        end else if (!bus.stallD) begin
            r_instrD    <= bus.instr_F;
            r_pcD       <= r_pcF;
            r_pcPlus4D  <= w_pcPlus4F;
            r_validD    <= 1'b1;
            r_misalignD <= r_misalignF;
        end
    end

    assign bus.pc_F       = r_pcF;
    assign bus.instr_D    = r_instrD;
    assign bus.pc_D       = r_pcD;
    assign bus.pc_plus4_D = r_pcPlus4D;
    assign bus.valid_D    = r_validD;
    assign bus.misalign_D = r_misalignD;

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.stallF),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.flushD),
        .cnt (bus.flush_cnt)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random hazards/redirects,
// compared every cycle against a behavioural model of the fetch/IF-ID rules.
module tb_fetch_stage;
    import rv_pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chkEn = 1'b0;
    int   nChecks = 0;
    int   nPass = 0;

    fetch_stage_if #(.CNT_W(CNT_W)) bus ();

    fetch_stage #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Instruction ROM: word at address a is 0x100 + a.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_0100 + a;
    endfunction

    assign bus.instr_F = rom(bus.pc_F);

    // Model state: what fetch and decode should be holding.
    logic [31:0] mPc, mInstrD, mPcD, mPc4D;
    logic        mMisF, mValidD, mMisD;
    int          mStall, mFlush;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc = RV_RESET_PC; mMisF = 0;
            mInstrD = RV_NOP; mPcD = 0; mPc4D = 0; mValidD = 0; mMisD = 0;
            mStall = 0; mFlush = 0;
        end else begin
            logic [31:0] fetchedPc;
            logic        fetchedMis;
            fetchedPc  = mPc;
            fetchedMis = mMisF;
            if (bus.flushD) begin
                mInstrD = RV_NOP; mPcD = 0; mPc4D = 0; mValidD = 0; mMisD = 0;
            end else if (!bus.stallD) begin
                mInstrD = rom(fetchedPc); mPcD = fetchedPc; mPc4D = fetchedPc + 32'd4;
                mValidD = 1; mMisD = fetchedMis;
            end
            if (bus.pc_src_E) begin
                mPc   = bus.pc_target_E & 32'hFFFF_FFFC;
                mMisF = (bus.pc_target_E % 4) != 0;
            end else if (!bus.stallF) begin
                mPc   = fetchedPc + 32'd4;
                mMisF = 0;
            end
            if (bus.stallF) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
            if (bus.flushD) mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Every cycle compare the DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("pc_F", bus.pc_F, mPc);
            checkOutput("instr_D", bus.instr_D, mInstrD);
            checkOutput("pc_D", bus.pc_D, mPcD);
            checkOutput("pc_plus4_D", bus.pc_plus4_D, mPc4D);
            checkOutput("valid_D", 32'(bus.valid_D), 32'(mValidD));
            checkOutput("misalign_D", 32'(bus.misalign_D), 32'(mMisD));
            checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(mStall));
            checkOutput("flush_cnt", 32'(bus.flush_cnt), 32'(mFlush));
        end
    end

    // Drive one cycle of inputs in the low phase, return just after the next falling edge.
    task automatic applyStimulus(input logic sF, input logic sD, input logic fl,
                                 input logic src, input logic [31:0] tgt);
        bus.stallF = sF; bus.stallD = sD; bus.flushD = fl;
        bus.pc_src_E = src; bus.pc_target_E = tgt;
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    initial begin
        bus.stallF = 0; bus.stallD = 0; bus.flushD = 0;
        bus.pc_src_E = 0; bus.pc_target_E = 0;
        repeat (2) @(negedge clk);
        #2;
        chkEn = 1;
        checkOutput("rst_pc_F", bus.pc_F, 32'h0);
        checkOutput("rst_instr_D", bus.instr_D, 32'h13);
        checkOutput("rst_valid_D", 32'(bus.valid_D), 32'h0);
        checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);

        rst = 0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run_pc_F", bus.pc_F, 32'h4);
        checkOutput("run_instr_D", bus.instr_D, 32'h100);
        checkOutput("run_valid_D", 32'(bus.valid_D), 32'h1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run_pc_F_10", bus.pc_F, 32'h10);

        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("stall_pc_F", bus.pc_F, 32'h10);
        checkOutput("stall_pc_D", bus.pc_D, 32'hC);
        checkOutput("stall_cnt_1", 32'(bus.stall_cnt), 32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("after_stall_pc_F", bus.pc_F, 32'h14);

        applyStimulus(1, 0, 1, 1, 32'h200);
        checkOutput("redir_pc_F", bus.pc_F, 32'h200);
        checkOutput("redir_instr_D", bus.instr_D, 32'h13);
        checkOutput("redir_valid_D", 32'(bus.valid_D), 32'h0);
        checkOutput("redir_flush_cnt", 32'(bus.flush_cnt), 32'h1);

        applyStimulus(0, 0, 0, 1, 32'h203);
        checkOutput("mis_pc_F", bus.pc_F, 32'h200);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_flag", 32'(bus.misalign_D), 32'h1);
        checkOutput("mis_pc_D", bus.pc_D, 32'h200);
        checkOutput("mis_instr_D", bus.instr_D, 32'h300);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_clear", 32'(bus.misalign_D), 32'h0);

        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_pc_F", bus.pc_F, 32'h0);
        checkOutput("wrap_pc_plus4_D", bus.pc_plus4_D, 32'h0);

        repeat (20) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sat_stall_cnt", 32'(bus.stall_cnt), 32'hF);

        for (int i = 0; i < 400; i++) begin
            logic sF, sD;
            sF = ($urandom_range(3) == 0);
            sD = sF ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
            applyStimulus(sF, sD, ($urandom_range(5) == 0), ($urandom_range(5) == 0), $urandom);
        end

        bus.stallF = 1; bus.stallD = 1; bus.flushD = 0; bus.pc_src_E = 0;
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        checkOutput("arst_pc_F", bus.pc_F, 32'h0);
        checkOutput("arst_instr_D", bus.instr_D, 32'h13);
        checkOutput("arst_valid_D", 32'(bus.valid_D), 32'h0);
        checkOutput("arst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        @(negedge clk);
        #2;
        rst = 0;
        checkOutput("arst_release_pc_F", bus.pc_F, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("arst_first_fetch_pc_D", bus.pc_D, 32'h0);

        chkEn = 0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 5-stage RISC-V pipeline: the PC register, PC+4 adder, redirect mux and IF/ID pipeline register.
- Directly upstream of decode.
- Consumes the stall requests (stallF, stallD) from the hazard unit and the taken-branch/jump redirect from execute.
- Drives the instruction-memory address and presents instr_D, pc_D and pc_plus4_D to decode, plus saturating stall/flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush or reset (addi x0,x0,0).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- stallF  in  1  hold PC (load-use hazard).
- stallD  in  1  hold IF/ID register.
- flushD  in  1  squash IF/ID contents (taken branch/jump resolved in E).
- pc_src_E  in  1  1 = redirect PC to pc_target_E.
- pc_target_E  in  32  branch/jump target from execute.
- instr_F  in  32  instruction read combinationally from imem at pc_F.
- pc_F  out  32  current PC, instruction-memory address.
- instr_D  out  32  registered instruction to decode.
- pc_D  out  32  registered PC of instr_D.
- pc_plus4_D  out  32  registered pc_D+4, used for the JAL/JALR link value.
- valid_D  out  1  1 = instr_D is a real fetched instruction, 0 = bubble.
- misalign_D  out  1  registered flag: instr_D was fetched from a redirect target with bits [1:0] != 0.
- stall_cnt  out  CNT_W  cycles with stallF=1 since reset, saturating.
- flush_cnt  out  CNT_W  cycles with flushD=1 since reset, saturating.

Behaviour:
- Reset is asynchronous: while rst=1, every flop is held at its reset value.
  - pc_F=RESET_PC, instr_D=NOP_INSTR, pc_D=0, pc_plus4_D=0, valid_D=0, misalign_D=0, stall_cnt=0, flush_cnt=0.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
  - The first fetch after deassertion is from RESET_PC.
- pc_plus4_F = pc_F + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0 silently.
- pc_next is chosen in this priority order:
  1. pc_src_E=1: {pc_target_E[31:2],2'b00}. Redirect overrides stallF because the hazarding instruction in D is being squashed.
  2. stallF=1: pc_F (hold).
  3. Otherwise: pc_plus4_F.
- pc_F updates every rising edge to pc_next. Latency from redirect to fetch at the target is 1 cycle.
- Misalign tracking:
  - Internal flop misalign_F is set when the redirect is taken and pc_target_E[1:0]!=0.
  - It clears on the next non-stalled PC advance and holds while stallF=1.
  - The flag travels with the instruction into IF/ID.
- IF/ID register, per rising edge, in this priority order:
  1. flushD=1: instr_D<=NOP_INSTR, pc_D<=0, pc_plus4_D<=0, valid_D<=0, misalign_D<=0. Flush wins over stallD when both are asserted.
  2. stallD=1: all IF/ID outputs hold.
  3. Otherwise: capture instr_F, pc_F, pc_plus4_F, valid_D<=1, misalign_D<=misalign_F.
- stallF=1 with stallD=0 is legal; the same PC is captured twice.
- Counters:
  - stall_cnt increments each cycle stallF=1; flush_cnt increments each cycle flushD=1.
  - Both hold at all-ones (saturate, no wrap).
- No combinational path from any input to pc_F. All outputs are registered.

Decomposition:
- Shared package (rv_pipe_pkg): XLEN=32, NOP_INSTR constant, RESET_PC default, and the PC-select encoding (PCSEL_SEQ, PCSEL_HOLD, PCSEL_TARGET) if encoded rather than priority-coded.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice for stall_cnt and flush_cnt.
- The IF/ID register stays inline.

Test Plan:
- Reset/run: release rst, instr_F tracks a ROM with 0x100 at address 0 -> pc_F = 0,4,8,... each cycle; instr_D appears one cycle later; pc_plus4_D = pc_D+4; valid_D=1 from cycle 2.
- Load-use stall: stallF=stallD=1 for 1 cycle with pc_F=0x10 -> pc_F stays 0x10 and IF/ID holds for that cycle; stall_cnt increments by 1; next cycle pc_F=0x14.
- Branch redirect: pc_src_E=1, flushD=1, pc_target_E=0x200 while stallF=1 -> next cycle pc_F=0x200, instr_D=0x13, valid_D=0, flush_cnt=1.
- Misaligned target: pc_target_E=0x203, pc_src_E=1 -> pc_F=0x200; one cycle later misalign_D=1 with pc_D=0x200; following instruction has misalign_D=0.
- Wrap and saturation:
  - Force pc_F=0xFFFF_FFFC with no stall -> next pc_F=0.
  - With CNT_W=4, 20 stall cycles -> stall_cnt=15.
- Asynchronous reset mid-stall: assert rst between clock edges during a stall -> outputs go to reset values immediately (before the next edge); after release pc_F=RESET_PC.
